// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: 2-entry elastic buffer (main + skid) carrying PC, instruction and operands.
// Latency: 1 cycle from accept to output when the stage is empty or draining.
// Backpressure: in_ready decoded from state only; skid entry absorbs one cycle of downstream stall.
module pipe_stage_reg #(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  IR_WIDTH  = 32,
  parameter int                  OP_WIDTH  = 32,
  parameter int                  NUM_OPS   = 2,
  parameter logic [IR_WIDTH-1:0] NOP_INSN  = 32'h00000000,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_WIDTH-1:0]          pc_in,
  input  logic [IR_WIDTH-1:0]          ir_in,
  input  logic [NUM_OPS*OP_WIDTH-1:0]  ops_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic [IR_WIDTH-1:0]          ir_out,
  output logic [NUM_OPS*OP_WIDTH-1:0]  ops_out,
  output logic [1:0]                   occupancy,
  output logic [CNT_WIDTH-1:0]         stall_cycles
);

  localparam int OPS_W = NUM_OPS * OP_WIDTH;
  localparam int ENT_W = PC_WIDTH + IR_WIDTH + OPS_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ENT_W-1:0]     main_q, main_d;
  logic [ENT_W-1:0]     skid_q, skid_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [ENT_W-1:0]     in_ent;
  logic                 accept;
  logic                 drain;

  // Entry layout: {pc, ir, ops}, ops packed LSB-first.
  assign in_ent       = {pc_in, ir_in, ops_in};
  assign accept       = in_valid & in_ready;
  assign drain        = out_valid & out_ready;
  assign stall_cycles = stall_q;

  // State, data and stall counter registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Next state and data loads; flush discards everything and suppresses any load so
  // a flushed entry can never reach the outputs.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_ent;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = in_ent;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_ent;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Saturating count of cycles where a valid head is held back by downstream.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Outputs decoded from state and the main entry; a bubble shows NOP while pc/ops hold.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      ST_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
    pc_out  = main_q[ENT_W-1 -: PC_WIDTH];
    ir_out  = (state_q == ST_EMPTY) ? NOP_INSN : main_q[OPS_W +: IR_WIDTH];
    ops_out = main_q[OPS_W-1:0];
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: queue scoreboard of accepted entries compared against the head.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven per scenario, including random stall patterns.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h00000000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [23:0] ops;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc_in = '0;
  logic [31:0] ir_in = '0;
  logic [23:0] ops_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic [23:0] ops_out;
  logic [1:0]  occupancy;
  logic [1:0]  stall_cycles;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t mq[$];
  ent_t cur;
  logic [1:0] stall_m = '0;

  pipe_stage_reg #(
    .PC_WIDTH(32), .IR_WIDTH(32), .OP_WIDTH(8), .NUM_OPS(3),
    .NOP_INSN(32'h00000000), .CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .ir_in(ir_in), .ops_in(ops_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .ir_out(ir_out), .ops_out(ops_out),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [23:0] ops, input logic ordy);
    in_valid  = v;
    pc_in     = pc;
    ir_in     = $urandom;
    ops_in    = ops;
    out_ready = ordy;
    cur       = '{pc: pc, ir: ir_in, ops: ops};
  endtask

  // Advance one edge and update the reference queue / stall model with pre-edge inputs.
  task automatic tick();
    bit acc, drn;
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    if (mq.size() > 0 && !out_ready && stall_m != 2'd3) stall_m = stall_m + 2'd1;
    @(posedge clk);
    #1;
    if (flush) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(cur);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0)  begin n_err++; $display("FAIL rst_occ got %0d want 0", occupancy); end
    n_cmp++; if (ir_out !== NOP)      begin n_err++; $display("FAIL rst_ir got %h want %h", ir_out, NOP); end
    n_cmp++; if (pc_out !== 32'h0)    begin n_err++; $display("FAIL rst_pc got %h want 0", pc_out); end
    n_cmp++; if (ops_out !== 24'h0)   begin n_err++; $display("FAIL rst_ops got %h want 0", ops_out); end
    n_cmp++; if (stall_cycles !== 2'd0) begin n_err++; $display("FAIL rst_stall got %0d want 0", stall_cycles); end
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    stall_m = '0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 24'($urandom), 1'b1);
      tick();
      n_cmp++; if (pc_out !== mq[0].pc) begin n_err++; $display("FAIL stream_pc%0d got %h want %h", i, pc_out, mq[0].pc); end
      n_cmp++; if (ops_out !== mq[0].ops) begin n_err++; $display("FAIL stream_ops%0d got %h want %h", i, ops_out, mq[0].ops); end
      n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stream_occ%0d got %0d want 1", i, occupancy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_rdy%0d got %b want 1", i, in_ready); end
    end
    drive(1'b0, 32'h0, 24'h0, 1'b1);
    tick();
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stream_end_occ got %0d want 0", occupancy); end
    n_cmp++; if (ir_out !== NOP) begin n_err++; $display("FAIL stream_end_ir got %h want %h", ir_out, NOP); end
    n_cmp++; if (pc_out !== 32'h8) begin n_err++; $display("FAIL stream_end_pc_hold got %h want 8", pc_out); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h10, 24'($urandom), 1'b0); tick();
    drive(1'b1, 32'h14, 24'($urandom), 1'b0); tick();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ got %0d want 2", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_rdy got %b want 0", in_ready); end
    n_cmp++; if (pc_out !== 32'h10) begin n_err++; $display("FAIL bp_pc got %h want 10", pc_out); end
    drive(1'b1, 32'h18, 24'($urandom), 1'b0); tick();
    n_cmp++; if (pc_out !== 32'h10) begin n_err++; $display("FAIL bp_full_pc got %h want 10", pc_out); end
    drive(1'b0, 32'h0, 24'h0, 1'b1); tick();
    n_cmp++; if (pc_out !== 32'h14 || occupancy !== 2'd1) begin n_err++; $display("FAIL bp_rel pc %h occ %0d want 14/1", pc_out, occupancy); end
    n_cmp++; if (ops_out !== mq[0].ops) begin n_err++; $display("FAIL bp_rel_ops got %h want %h", ops_out, mq[0].ops); end
    tick();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain occ %0d vld %b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h30, 24'($urandom), 1'b0); tick();
    drive(1'b1, 32'h34, 24'($urandom), 1'b0); tick();
    drive(1'b1, 32'h20, 24'($urandom), 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    n_cmp++; if (ir_out !== NOP) begin n_err++; $display("FAIL flush_ir got %h want %h", ir_out, NOP); end
    n_cmp++; if (pc_out !== 32'h30) begin n_err++; $display("FAIL flush_pc got %h want 30", pc_out); end
    drive(1'b0, 32'h0, 24'h0, 1'b1); tick();
    n_cmp++; if (out_valid !== 1'b0 || pc_out === 32'h20) begin n_err++; $display("FAIL flush_after vld %b pc %h want 0/not 20", out_valid, pc_out); end
  endtask

  task automatic test_stall();
    int exp_st[5] = '{1, 2, 3, 3, 3};
    rst = 1'b1; #2; rst = 1'b0;
    mq.delete(); stall_m = '0;
    drive(1'b1, 32'h60, 24'($urandom), 1'b0); tick();
    n_cmp++; if (stall_cycles !== 2'd0) begin n_err++; $display("FAIL stall_start got %0d want 0", stall_cycles); end
    drive(1'b0, 32'h0, 24'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (stall_cycles !== 2'(exp_st[i]) || stall_cycles !== stall_m) begin
        n_err++; $display("FAIL stall_cnt%0d got %0d want %0d", i, stall_cycles, exp_st[i]);
      end
    end
    flush = 1'b1; tick(); flush = 1'b0;
    n_cmp++; if (stall_cycles !== 2'd3) begin n_err++; $display("FAIL stall_flush got %0d want 3", stall_cycles); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h70, 24'($urandom), 1'b0); tick();
    drive(1'b1, 32'h74, 24'($urandom), 1'b0); tick();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL areset_pre occ %0d want 2", occupancy); end
    #3; rst = 1'b1; #1;
    n_cmp++; if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL areset_ctl occ %0d rdy %b vld %b want 0/1/0", occupancy, in_ready, out_valid);
    end
    n_cmp++; if (pc_out !== 32'h0 || ops_out !== 24'h0 || ir_out !== NOP || stall_cycles !== 2'd0) begin
      n_err++; $display("FAIL areset_dat pc %h ops %h ir %h st %0d want zeros", pc_out, ops_out, ir_out, stall_cycles);
    end
    #1; rst = 1'b0;
    mq.delete(); stall_m = '0;
    drive(1'b1, 32'h80, 24'($urandom), 1'b1); tick();
    n_cmp++; if (pc_out !== 32'h80 || occupancy !== 2'd1 || ir_out !== cur.ir) begin
      n_err++; $display("FAIL areset_resume pc %h occ %0d ir %h want 80/1/%h", pc_out, occupancy, ir_out, cur.ir);
    end
  endtask

  task automatic test_ops();
    drive(1'b1, 32'h90, 24'hCCBBAA, 1'b1); tick();
    n_cmp++; if (ops_out !== 24'hCCBBAA) begin n_err++; $display("FAIL ops_pack got %h want ccbbaa", ops_out); end
    drive(1'b0, 32'h0, 24'h0, 1'b1); tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 32'(32'h100 + i * 4), 24'($urandom), 1'($urandom_range(0, 1)));
      tick();
      n_cmp++; if (occupancy !== 2'(mq.size()) || in_ready !== (mq.size() < 2) || out_valid !== (mq.size() > 0)) begin
        n_err++; $display("FAIL b2b_ctl%0d occ %0d rdy %b vld %b want occ %0d", i, occupancy, in_ready, out_valid, mq.size());
      end
      if (mq.size() > 0) begin
        n_cmp++; if (pc_out !== mq[0].pc || ir_out !== mq[0].ir || ops_out !== mq[0].ops) begin
          n_err++; $display("FAIL b2b_dat%0d got %h/%h/%h want %h/%h/%h", i, pc_out, ir_out, ops_out, mq[0].pc, mq[0].ir, mq[0].ops);
        end
      end else begin
        n_cmp++; if (ir_out !== NOP) begin n_err++; $display("FAIL b2b_nop%0d got %h want %h", i, ir_out, NOP); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall();
    test_async_reset();
    test_ops();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The module SHALL have parameter PC_WIDTH, 32, width of program-counter field.
REQ-002 The module SHALL have parameter IR_WIDTH, 32, width of instruction field.
REQ-003 The module SHALL have parameter OP_WIDTH, 32, width of each operand field.
REQ-004 The module SHALL have parameter NUM_OPS, 2, number of operand fields (A, B, ...) carried, packed LSB-first.
REQ-005 The module SHALL have parameter NOP_INSN, 32'h00000000, instruction presented when the stage holds a bubble.
REQ-006 The module SHALL have parameter CNT_WIDTH, 16, width of the stall-cycle counter.
REQ-007 The module SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-008 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-009 The module SHALL have port flush  input  1  discard all held entries.
REQ-010 The module SHALL have port in_valid  input  1  upstream entry present.
REQ-011 The module SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-012 The module SHALL have port pc_in  input  PC_WIDTH  upstream PC.
REQ-013 The module SHALL have port ir_in  input  IR_WIDTH  upstream instruction.
REQ-014 The module SHALL have port ops_in  input  NUM_OPS*OP_WIDTH  upstream operands.
REQ-015 The module SHALL have port out_valid  output  1  downstream entry present.
REQ-016 The module SHALL have port out_ready  input  1  downstream accepts (0 = stall).
REQ-017 The module SHALL have ports pc_out, ir_out, ops_out  output  same widths as inputs  head entry.
REQ-018 The module SHALL have port occupancy  output  2  number of held entries (0..2).
REQ-019 The module SHALL have port stall_cycles  output  CNT_WIDTH  saturating count of stalled cycles.

Function
REQ-020 The stage SHALL be a 2-entry elastic buffer (main + skid) with states EMPTY, ONE, FULL; outputs always driven from main.
REQ-021 accept = in_valid & in_ready; drain = out_valid & out_ready, both sampled at the rising edge.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, decoded from the state register only (no combinational path from out_ready).
REQ-023 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY; occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.
REQ-024 EMPTY: accept -> ONE, main loaded; else stay.
REQ-025 ONE: accept & drain -> ONE, main reloaded; accept & !drain -> FULL, skid loaded; !accept & drain -> EMPTY; neither -> stay.
REQ-026 FULL: drain -> ONE, main <= skid; else stay; no accept possible.
REQ-027 Entries SHALL leave in arrival order; no entry SHALL be duplicated or dropped except by flush.
REQ-028 Latency SHALL be 1 cycle: an entry accepted at edge N appears on outputs after edge N when the stage was EMPTY or draining.
REQ-029 flush SHALL force next state EMPTY, overriding accept and drain in the same cycle; an entry offered during flush SHALL be discarded.
REQ-030 In EMPTY, ir_out SHALL equal NOP_INSN; pc_out and ops_out SHALL hold their last values.
REQ-031 stall_cycles SHALL increment each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_WIDTH-1, and be unaffected by flush.
REQ-032 Held main/skid data SHALL not change while state does not change.

Reset
REQ-033 rst=1 SHALL immediately force state EMPTY, in_ready=1, out_valid=0, occupancy=0, ir_out=NOP_INSN, pc_out=0, ops_out=0, stall_cycles=0, independent of clk.
REQ-034 Reset asserted mid-transfer SHALL discard all held entries; first edge after release SHALL behave as from EMPTY.

Verification
REQ-035 Stream: in_valid=1 with pc 0x0,0x4,0x8, out_ready=1 -> out pc 0x0,0x4,0x8 one cycle later each, occupancy stays 1, in_ready stays 1.
REQ-036 Backpressure: out_ready=0, push pc 0x10,0x14 -> occupancy 2, in_ready=0, pc_out=0x10; release out_ready -> 0x10 then 0x14, no loss.
REQ-037 Flush in FULL with in_valid=1 pc 0x20 -> next cycle occupancy 0, ir_out=NOP_INSN, 0x20 never appears.
REQ-038 Stall counter with CNT_WIDTH=2: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cycles 1,2,3,3,3.
REQ-039 Async reset asserted between edges while FULL -> outputs reach reset values before next edge; accept resumes normally after release.
REQ-040 NUM_OPS=3, OP_WIDTH=8: ops_in 24'hCCBBAA -> ops_out 24'hCCBBAA after 1 cycle.
